// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the control FSM encoding and the bit-counter width rule.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with the borrow out.
// Purely combinational, zero latency, no flow control.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first; done pulses WIDTH edges after the accepting edge.
// start is ignored while busy; optional signed overflow output under SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_next;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    // The new bit enters at the MSB so after WIDTH shifts diff_sr is LSB-aligned.
    assign diff_next = {d, diff_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow   <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= diff_next;
                    borrow  <= bout;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff       <= diff_next;
                        borrow_out <= bout;
                        done       <= 1'b1;
                        state      <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        overflow   <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock. This is the inverse operation of the team's adder cells.
- Built around a single full-subtractor bit cell and a registered borrow.
- Start/done handshake; result held stable until the next accepted start.
- Serves area-constrained datapaths where a WIDTH-bit parallel subtractor is not justified.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only while idle.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal shift registers, borrow and counter all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on an edge with start=1:
  - latch a and b into operand shift registers;
  - clear the borrow flop and the bit counter.
- SHIFT, every edge:
  - cell inputs x=a_sr[0], y=b_sr[0], bin=borrow;
  - d = x^y^bin; bout = (~x&y) | (~(x^y)&bin);
  - diff_sr shifts right with d entering at the MSB;
  - a_sr and b_sr shift right; borrow <= bout; counter increments.
- SHIFT -> DONE on the edge processing bit WIDTH-1 (counter == WIDTH-1).
  - On that same edge: diff <= final diff_sr value, borrow_out <= bout.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start sampled at edge E. Bits are processed at edges E+1..E+WIDTH. done is high between edges E+WIDTH and E+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 (SHIFT or DONE) is ignored; no queueing.
- diff and borrow_out change only on the final SHIFT edge, and are held through DONE and IDLE until the next operation completes.
- Changes on a and b after the accepting edge have no effect.
- Reset mid-operation aborts immediately: all outputs return to reset values, no done pulse.
- Counter width is $clog2(WIDTH)+1. No wrap occurs within an operation.

Optional Feature:
- Macro SERIAL_SUB_OVERFLOW_EN.
- When defined:
  - extra output port overflow (1 bit, reset 0);
  - a_msb and b_msb are captured at start;
  - on the final SHIFT edge, overflow <= (a_msb != b_msb) && (d != a_msb), i.e. two's-complement signed overflow;
  - overflow is held like diff.
- When undefined: no port, no capture flops; behaviour otherwise identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum type (IDLE, SHIFT, DONE);
  - localparam DEFAULT_WIDTH=8;
  - function cnt_width(w) returning $clog2(w)+1.
- Sub-module full_subtractor:
  - purely combinational;
  - ports x, y, bin, d, bout;
  - instantiated once as the bit cell.
- Control and shift registers live in serial_subtractor.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start pulse -> busy for 9 cycles; done at edge E+8 window; diff=0x02, borrow_out=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0xFF -> diff=0x01, borrow_out=1; a=b=0xA5 -> diff=0x00, borrow_out=0.
- Accept a=0x10, b=0x01; change a/b and pulse start again at E+3 -> second start ignored; result diff=0x0F, a single done pulse only.
- Assert rst_n=0 at E+4 mid-operation -> busy, done, diff, borrow_out go 0 asynchronously; after release, a new start with a=0x09, b=0x04 yields diff=0x05.
- Back-to-back: start held high continuously -> operations accepted every WIDTH+2 cycles; each done is exactly one cycle wide.
- With SERIAL_SUB_OVERFLOW_EN defined:
  - a=0x80, b=0x01 -> diff=0x7F, overflow=1;
  - a=0x7F, b=0x01 -> diff=0x7E, overflow=0.
